uart_byte_rx: RTL and testbench

Bit-level UART receiver: synchronises the raw `rx` line and validates start bits against glitches. It samples 8N1 frames at mid-bit and hands each completed byte to the downstream `Uart` word assembler as a one-cycle strobe. It also reports framing errors and provides the idle-timeout indication that `Uart` uses to raise `Done`. One instance sits between the board RX pin and `Uart`.

---
 rtl/uart_byte_rx_if.sv | 13 +
 rtl/uart_byte_rx.sv | 130 +++++++++++++
 tb/tb_uart_byte_rx.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/uart_byte_rx_if.sv
// Serial-side bundle between the RX pin logic and the byte consumer.
// The slave modport is the receiver; the master modport drives the line and observes results.
interface uart_byte_rx_if;
   logic       rx;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       busy;
   logic       idle_timeout;

   modport master (output rx, input rx_data, rx_valid, frame_err, busy, idle_timeout);
   modport slave  (input rx, output rx_data, rx_valid, frame_err, busy, idle_timeout);
endinterface

// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver: synchronised rx, glitch-checked start bit, mid-bit sampling,
// framing-error pulse and an idle timeout armed by the first good byte.
module uart_byte_rx #(
   parameter int BPS_CNT  = 434,
   parameter int MAX_IDLE = 5_000_000
) (
   input  logic           clk,
   input  logic           reset,
   uart_byte_rx_if.slave  bus
);
   localparam int HALF  = BPS_CNT / 2;
   localparam int CNT_W = $clog2(BPS_CNT);
   localparam int IDL_W = $clog2(MAX_IDLE + 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
   localparam logic [CNT_W-1:0] CNT_BIT  = CNT_W'(BPS_CNT - 1);
   localparam logic [IDL_W-1:0] IDL_MAX  = IDL_W'(MAX_IDLE);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_HIGH} state_t;

   state_t           state_q, state_d;
   logic [1:0]       sync_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       idx_q, idx_d;
   logic [7:0]       shreg_q, shreg_d;
   logic [7:0]       data_q, data_d;
   logic             valid_q, valid_d;
   logic             ferr_q, ferr_d;
   logic [IDL_W-1:0] idle_q, idle_d;
   logic             armed_q, armed_d;
   logic             rx_s, busy;

   assign rx_s = sync_q[1];
   assign busy = (state_q != S_IDLE);

   // Synchroniser resets to the idle-high line level so reset never looks like a start bit.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) sync_q <= 2'b11;
      else        sync_q <= {sync_q[0], bus.rx};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shreg_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         idle_q  <= '0;
         armed_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shreg_q <= shreg_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
         idle_q  <= idle_d;
         armed_q <= armed_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shreg_d = shreg_q;
      data_d  = data_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!rx_s) begin
               state_d = S_START;
               cnt_d   = '0;
            end
         end
         S_START: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_HALF) begin
               cnt_d   = '0;
               idx_d   = '0;
               state_d = rx_s ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_BIT) begin
               cnt_d          = '0;
               shreg_d[idx_q] = rx_s;
               if (idx_q == 3'd7) state_d = S_STOP;
               else               idx_d   = idx_q + 3'd1;
            end
         end
         S_STOP: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_BIT) begin
               cnt_d = '0;
               if (rx_s) begin
                  data_d  = shreg_q;
                  valid_d = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = S_WAIT_HIGH;
               end
            end
         end
         S_WAIT_HIGH: if (rx_s) state_d = S_IDLE;
         default:     state_d = S_IDLE;
      endcase
   end

   // Every good byte ends a busy stretch, so holding the counter at zero while busy
   // already leaves it at zero in the rx_valid cycle; it counts up from there.
   always_comb begin
      idle_d  = idle_q;
      armed_d = armed_q | valid_q;
      if (busy)                   idle_d = '0;
      else if (idle_q != IDL_MAX) idle_d = idle_q + 1'b1;
   end

   assign bus.rx_data      = data_q;
   assign bus.rx_valid     = valid_q;
   assign bus.frame_err    = ferr_q;
   assign bus.busy         = busy;
   assign bus.idle_timeout = armed_q && (idle_q == IDL_MAX);
endmodule

// File: tb/tb_uart_byte_rx.sv
// Directed bench for uart_byte_rx: frame timing, back-to-back, glitch, framing error,
// idle timeout and mid-frame reset.
module tb_uart_byte_rx;
   localparam int BPS  = 16;
   localparam int MAXI = 200;

   logic clk = 1'b0;
   logic reset = 1'b0;
   uart_byte_rx_if bus();

   uart_byte_rx #(.BPS_CNT(BPS), .MAX_IDLE(MAXI)) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Pulse monitor, sampled on the falling edge.
   logic [7:0] vq[$];
   int         vc[$];
   int         fe_n = 0, fe_cyc = -1, to_rise = -1, to_fall = -1;
   logic       to_prev = 1'b0, to_seen = 1'b0;
   always @(negedge clk) begin
      if (bus.rx_valid) begin
         vq.push_back(bus.rx_data);
         vc.push_back(cyc);
      end
      if (bus.frame_err) begin
         fe_n   <= fe_n + 1;
         fe_cyc <= cyc;
      end
      if (bus.idle_timeout && !to_prev) to_rise <= cyc;
      if (!bus.idle_timeout && to_prev) to_fall <= cyc;
      if (bus.idle_timeout) to_seen <= 1'b1;
      to_prev <= bus.idle_timeout;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] qd(input int i);
      if (i < vq.size()) return 32'(vq[i]);
      return 32'hDEAD_BEEF;
   endfunction

   function automatic int qc(input int i);
      if (i < vc.size()) return vc[i];
      return -100000;
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One frame, LSB first; stop_low > 0 holds the stop bit low that many bit times first.
   task automatic send(input logic [7:0] d, input int stop_low);
      logic [9:0] f;
      f = {1'b1, d, 1'b0};
      for (int i = 0; i < 9; i++) begin
         bus.rx = f[i];
         tick(BPS);
      end
      if (stop_low > 0) begin
         bus.rx = 1'b0;
         tick(stop_low * BPS);
      end
      bus.rx = 1'b1;
      tick(BPS);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_data"},  32'(bus.rx_data), 32'h00);
      chk({tag, "_valid"}, 32'(bus.rx_valid), 32'h0);
      chk({tag, "_ferr"},  32'(bus.frame_err), 32'h0);
      chk({tag, "_busy"},  32'(bus.busy), 32'h0);
      chk({tag, "_to"},    32'(bus.idle_timeout), 32'h0);
   endtask

   initial begin
      int s, v, f0;
      bus.rx = 1'b1;
      tick(3);
      chk_reset_vals("rst");
      reset = 1'b1;

      // No traffic yet: counter saturates but timeout stays unarmed.
      tick(1000);
      chk("unarmed_to", 32'(to_seen), 32'h0);
      chk("idle_pulses", 32'(vq.size()), 32'h0);

      // 0x01 then idle timeout exactly MAXI cycles after rx_valid.
      s = cyc;
      send(8'h01, 0);
      tick(5);
      chk("b01_cnt", 32'(vq.size()), 32'd1);
      chk("b01_data", qd(0), 32'h01);
      chk("b01_lat", 32'(qc(0) - s), 32'd155);
      v = qc(0);
      tick(MAXI);
      chk("to_rise", 32'(to_rise - v), 32'd200);
      chk("to_level", 32'(bus.idle_timeout), 32'h1);

      // Single 0x55; timeout drops once busy is seen.
      vq.delete(); vc.delete();
      s = cyc;
      send(8'h55, 0);
      tick(5);
      chk("b55_cnt", 32'(vq.size()), 32'd1);
      chk("b55_data", qd(0), 32'h55);
      chk("b55_lat", 32'(qc(0) - s), 32'd155);
      chk("b55_ferr", 32'(fe_n), 32'd0);
      chk("to_fall", 32'(to_fall - s), 32'd4);

      // Back-to-back frames, no gap.
      vq.delete(); vc.delete();
      s = cyc;
      send(8'hAA, 0);
      send(8'hBB, 0);
      send(8'hCC, 0);
      tick(5);
      chk("b2b_cnt", 32'(vq.size()), 32'd3);
      chk("b2b_d0", qd(0), 32'hAA);
      chk("b2b_d1", qd(1), 32'hBB);
      chk("b2b_d2", qd(2), 32'hCC);
      chk("b2b_lat", 32'(qc(0) - s), 32'd155);
      chk("b2b_gap1", 32'(qc(1) - qc(0)), 32'd160);
      chk("b2b_gap2", 32'(qc(2) - qc(1)), 32'd160);

      // 5-cycle low glitch.
      vq.delete(); vc.delete();
      f0 = fe_n;
      bus.rx = 1'b0;
      tick(5);
      bus.rx = 1'b1;
      for (int k = 0; k < 10 && bus.busy; k++) tick(1);
      chk("glitch_busy", 32'(bus.busy), 32'h0);
      tick(30);
      chk("glitch_valid", 32'(vq.size()), 32'd0);
      chk("glitch_ferr", 32'(fe_n - f0), 32'd0);
      chk("glitch_data", 32'(bus.rx_data), 32'hCC);

      // Stop bit held low for 3 bit times, then a good frame.
      s = cyc;
      send(8'h3C, 3);
      tick(5);
      chk("ferr_cnt", 32'(fe_n - f0), 32'd1);
      chk("ferr_lat", 32'(fe_cyc - s), 32'd155);
      chk("ferr_valid", 32'(vq.size()), 32'd0);
      chk("ferr_data", 32'(bus.rx_data), 32'hCC);
      tick(10);
      s = cyc;
      send(8'h12, 0);
      tick(5);
      chk("b12_cnt", 32'(vq.size()), 32'd1);
      chk("b12_data", qd(0), 32'h12);
      chk("b12_lat", 32'(qc(0) - s), 32'd155);

      // Reset in the middle of data bit 4 of 0x77.
      vq.delete(); vc.delete();
      fork
         send(8'h77, 0);
         begin
            tick(88);
            chk("pre_rst_busy", 32'(bus.busy), 32'h1);
            #2;
            reset = 1'b0;
            #1;
            chk_reset_vals("mid_rst");
         end
      join
      chk("rst_no_valid", 32'(vq.size()), 32'd0);
      reset = 1'b1;
      tick(20);
      s = cyc;
      send(8'h99, 0);
      tick(5);
      chk("b99_cnt", 32'(vq.size()), 32'd1);
      chk("b99_data", qd(0), 32'h99);
      chk("b99_out", 32'(bus.rx_data), 32'h99);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
